// File: rtl/onehot_state_decoder.sv
// onehot_state_decoder: observer/decoder for a one-hot FSM state bus.
// Encodes each sample to a binary index and flags zero-hot and multi-hot
// samples with sticky flags. Also tracks how long each state is held and
// counts entries into one watched state.
// Ports:
//   clk, resetb        clock, synchronous active-low reset
//   state_in [N]       one-hot state bus under observation
//   clear              sync clear of sticky errors and statistics
//   idx [W]            index of last legal state
//   valid              last sample was legal
//   change             pulse on entry into a legal new state
//   dwell [CNTW]       consecutive samples of current idx (saturating)
//   last_dwell [CNTW]  dwell of previous state, captured on change
//   watch_count [CNTW] entries into state WATCH (saturating)
//   err_zero/err_multi sticky zero-hot / multi-hot flags
//   err_count [8]      illegal sample count (saturating)
module onehot_state_decoder #(
  parameter int unsigned N     = 16,
  parameter int unsigned W     = $clog2(N),
  parameter int unsigned CNTW  = 16,
  parameter int unsigned WATCH = 1
) (
  input  logic            clk,
  input  logic            resetb,
  input  logic [N-1:0]    state_in,
  input  logic            clear,
  output logic [W-1:0]    idx,
  output logic            valid,
  output logic            change,
  output logic [CNTW-1:0] dwell,
  output logic [CNTW-1:0] last_dwell,
  output logic [CNTW-1:0] watch_count,
  output logic            err_zero,
  output logic            err_multi,
  output logic [7:0]      err_count
);

  localparam int unsigned ECW = 8;

  logic            is_zero;
  logic            is_multi;
  logic            is_legal;
  logic [W-1:0]    enc;
  logic [W-1:0]    idx_d;
  logic            valid_d;
  logic            change_d;
  logic [CNTW-1:0] dwell_d;
  logic [CNTW-1:0] last_dwell_d;
  logic [CNTW-1:0] watch_count_d;
  logic            err_zero_d;
  logic            err_multi_d;
  logic [ECW-1:0]  err_count_d;

  // Classify the sample; x & (x-1) is nonzero iff more than one bit is set.
  always_comb begin
    is_zero  = ~|state_in;
    is_multi = |(state_in & (state_in - N'(1)));
    is_legal = ~is_zero & ~is_multi;
  end

  // OR-encoder: exact only for one-hot input, which is all that is used.
  always_comb begin
    enc = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (state_in[i]) enc = enc | W'(i);
    end
  end

  // Next-state for all registered outputs; clear is applied first so a
  // coincident event overrides it.
  always_comb begin
    idx_d         = idx;
    valid_d       = is_legal;
    change_d      = is_legal & (~valid | (enc != idx));
    dwell_d       = dwell;
    last_dwell_d  = clear ? '0 : last_dwell;
    watch_count_d = clear ? '0 : watch_count;
    err_zero_d    = clear ? 1'b0 : err_zero;
    err_multi_d   = clear ? 1'b0 : err_multi;
    err_count_d   = clear ? '0 : err_count;

    if (change_d) begin
      idx_d        = enc;
      last_dwell_d = dwell;
      dwell_d      = CNTW'(1);
      if (enc == W'(WATCH) && watch_count_d != '1)
        watch_count_d = watch_count_d + CNTW'(1);
    end else if (is_legal) begin
      if (dwell != '1) dwell_d = dwell + CNTW'(1);
    end

    if (!is_legal) begin
      if (is_zero)  err_zero_d  = 1'b1;
      if (is_multi) err_multi_d = 1'b1;
      if (err_count_d != '1) err_count_d = err_count_d + ECW'(1);
    end
  end

  // Output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!resetb) begin
      idx         <= '0;
      valid       <= 1'b0;
      change      <= 1'b0;
      dwell       <= '0;
      last_dwell  <= '0;
      watch_count <= '0;
      err_zero    <= 1'b0;
      err_multi   <= 1'b0;
      err_count   <= '0;
    end else begin
      idx         <= idx_d;
      valid       <= valid_d;
      change      <= change_d;
      dwell       <= dwell_d;
      last_dwell  <= last_dwell_d;
      watch_count <= watch_count_d;
      err_zero    <= err_zero_d;
      err_multi   <= err_multi_d;
      err_count   <= err_count_d;
    end
  end

endmodule
